// File: rtl/vpu_inst_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : vpu_inst_dispatch
// Purpose  : Instruction FIFO plus round-robin issue of 32b VPU instructions to
//            idle lanes. FENCE (opcode all-ones) drains every lane before issue
//            resumes. Optional stall counter: VPU_DISPATCH_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vpu_inst_dispatch #(
    parameter int M     = 4,
    parameter int DEPTH = 8,
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [31:0]          in_inst,
    output logic                 in_ready,
    input  logic                 enable,
    output logic [M-1:0][31:0]   lane_inst,
    output logic [M-1:0]         lane_start,
    input  logic [M-1:0]         lane_done,
    output logic [M-1:0]         lane_busy,
    output logic                 idle,
    output logic [CNT_W-1:0]     issued_cnt,
    output logic                 err_spurious,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam int c_lane_w = (M > 1) ? $clog2(M) : 1;

    logic [31:0]         r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_lane_w-1:0] r_rr_ptr;
    logic [M-1:0][31:0]  r_lane_inst;
    logic [M-1:0]        r_lane_start;
    logic [M-1:0]        r_lane_busy;
    logic [CNT_W-1:0]    r_issued_cnt;
    logic                r_err;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [31:0]         w_head;
    logic                w_is_fence;
    logic                w_found;
    logic [c_lane_w-1:0] w_pick;
    logic                w_issue;
    logic                w_fence_pop;
    logic [M-1:0]        w_issue_vec;
    logic [c_lane_w-1:0] w_rr_next;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_cnt_w'(DEPTH));
    assign w_push     = in_valid && !w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_is_fence = (w_head[OP_W-1:0] == {OP_W{1'b1}});

    // First idle lane at or after the round-robin pointer, wrapping.
    always_comb begin
        int w_idx;
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int k = 0; k < M; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % M;
            if (!w_found && !r_lane_busy[w_idx]) begin
                w_found = 1'b1;
                w_pick  = c_lane_w'(w_idx);
            end
        end
    end

    assign w_issue     = enable && !w_empty && !w_is_fence && w_found;
    assign w_fence_pop = enable && !w_empty && w_is_fence &&
                         (r_lane_busy == '0) && (r_lane_start == '0);
    assign w_pop       = w_issue || w_fence_pop;
    assign w_rr_next   = c_lane_w'((int'(w_pick) + 1) % M);

    always_comb begin
        w_issue_vec = '0;
        if (w_issue) w_issue_vec[w_pick] = 1'b1;
    end

    // Storage carries no reset; occupancy is governed solely by r_count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_inst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_rr_ptr     <= '0;
            r_lane_inst  <= '0;
            r_lane_start <= '0;
            r_lane_busy  <= '0;
            r_issued_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            r_lane_start <= w_issue_vec;
            r_lane_busy  <= (r_lane_busy & ~lane_done) | w_issue_vec;
            for (int l = 0; l < M; l++) begin
                if (w_issue_vec[l]) r_lane_inst[l] <= w_head;
            end
            if (w_issue) begin
                r_rr_ptr     <= w_rr_next;
                r_issued_cnt <= r_issued_cnt + CNT_W'(1);
            end
            if (|(lane_done & ~r_lane_busy)) r_err <= 1'b1;
        end
    end

`ifdef VPU_DISPATCH_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (enable && !w_empty && !w_pop) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

    assign in_ready     = !w_full;
    assign lane_inst    = r_lane_inst;
    assign lane_start   = r_lane_start;
    assign lane_busy    = r_lane_busy;
    assign idle         = w_empty && (r_lane_busy == '0) && (r_lane_start == '0);
    assign issued_cnt   = r_issued_cnt;
    assign err_spurious = r_err;

endmodule
`default_nettype wire
